// File: rtl/ro_sampler_pkg.sv
// Shared types and default parameter values for the ring-oscillator
// entropy sampler.
package ro_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } ro_state_e;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_SAMPLE_DIV = 16;
  localparam int DEF_WARMUP_CYC = 64;
  localparam int DEF_REP_LIMIT  = 32;

endpackage

// File: rtl/ro_entropy_sampler_sync2.sv
// Two-flop synchroniser for one asynchronous oscillator output.
module sync2
  import ro_sampler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // two-stage capture of an asynchronous level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ro_entropy_sampler.sv
// Ring-oscillator entropy sampler: synchronises and XORs four oscillator
// outputs, samples at a divided rate, packs bits LSB-first into words on a
// valid/ready stream, and locks out on a repetition-count health failure.
// Optional macro RO_SAMPLER_VN_EN enables Von Neumann debiasing of samples.
module ro_entropy_sampler
  import ro_sampler_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              osc_en,
  input  logic              f0,
  input  logic              f1,
  input  logic              f2,
  input  logic              f3,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              fault
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int CNT_W  = $clog2(WORD_W + 1);

  logic [3:0]        f_sync_s;
  logic              raw_s;
  ro_state_e         state_r;
  ro_state_e         state_nxt_s;
  logic [DIV_W-1:0]  div_r;
  logic [WARM_W-1:0] warm_r;
  logic [REP_W-1:0]  rep_r;
  logic [REP_W-1:0]  rep_nxt_s;
  logic              prev_r;
  logic              tick_s;
  logic              trip_s;
  logic              clear_s;
  logic              acc_s;
  logic              acc_bit_s;
  logic [WORD_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              full_s;
  logic              load_s;
  logic [WORD_W-1:0] data_r;
  logic              valid_r;
  logic              osc_en_r;
  logic              fault_r;
  logic              osc_en_nxt_s;
  logic              fault_nxt_s;

  sync2 u_sync0 (.clk(clk), .rst_n(rst_n), .d(f0), .q(f_sync_s[0]));
  sync2 u_sync1 (.clk(clk), .rst_n(rst_n), .d(f1), .q(f_sync_s[1]));
  sync2 u_sync2 (.clk(clk), .rst_n(rst_n), .d(f2), .q(f_sync_s[2]));
  sync2 u_sync3 (.clk(clk), .rst_n(rst_n), .d(f3), .q(f_sync_s[3]));

  assign raw_s  = ^f_sync_s;
  assign tick_s = (state_r == RUN) && (div_r == DIV_W'(SAMPLE_DIV - 1));
  assign full_s = (cnt_r == CNT_W'(WORD_W));
  assign load_s = full_s && (!valid_r || ready);

  // repetition count after this tick; a tick that reaches the limit trips
  always_comb begin
    if ((rep_r == '0) || (raw_s != prev_r)) begin
      rep_nxt_s = REP_W'(1);
    end else begin
      rep_nxt_s = rep_r + REP_W'(1);
    end
    trip_s = tick_s && (rep_nxt_s == REP_W'(REP_LIMIT));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; dropping en always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (!en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = WARMUP;
        WARMUP: begin
          if (warm_r == WARM_W'(WARMUP_CYC - 1)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = WARMUP;
          end
        end
        RUN: begin
          if (trip_s) begin
            state_nxt_s = FAULT;
          end else begin
            state_nxt_s = RUN;
          end
        end
        FAULT:   state_nxt_s = FAULT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // output decode from the upcoming state so the outputs leave registers
  always_comb begin
    osc_en_nxt_s = (state_nxt_s == WARMUP) || (state_nxt_s == RUN);
    fault_nxt_s  = (state_nxt_s == FAULT);
    clear_s      = (state_nxt_s != RUN);
  end

  // registered oscillator enable and fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_en_r <= 1'b0;
      fault_r  <= 1'b0;
    end else begin
      osc_en_r <= osc_en_nxt_s;
      fault_r  <= fault_nxt_s;
    end
  end

  // warmup, sample divider and repetition counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_r <= '0;
      div_r  <= '0;
      rep_r  <= '0;
      prev_r <= 1'b0;
    end else begin
      if ((state_r == WARMUP) && (state_nxt_s == WARMUP)) begin
        warm_r <= warm_r + WARM_W'(1);
      end else begin
        warm_r <= '0;
      end
      if ((state_r == RUN) && (state_nxt_s == RUN)) begin
        div_r <= tick_s ? '0 : div_r + DIV_W'(1);
      end else begin
        div_r <= '0;
      end
      if (clear_s) begin
        rep_r  <= '0;
        prev_r <= 1'b0;
      end else if (tick_s) begin
        rep_r  <= rep_nxt_s;
        prev_r <= raw_s;
      end
    end
  end

`ifdef RO_SAMPLER_VN_EN
  logic phase_r;
  logic first_r;

  // pair phase and first bit of the current Von Neumann pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      first_r <= 1'b0;
    end else if (clear_s) begin
      phase_r <= 1'b0;
      first_r <= 1'b0;
    end else if (tick_s) begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        first_r <= raw_s;
      end
    end
  end

  // an unequal pair yields its first bit; equal pairs are discarded
  always_comb begin
    acc_bit_s = first_r;
    if (tick_s && !trip_s && phase_r && (first_r != raw_s)) begin
      acc_s = 1'b1;
    end else begin
      acc_s = 1'b0;
    end
  end
`else
  // every tick that does not trip the health test contributes its raw bit
  always_comb begin
    acc_s     = tick_s && !trip_s;
    acc_bit_s = raw_s;
  end
`endif

  // shift register packing LSB-first, output register and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (clear_s) begin
      shift_r <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (load_s) begin
      data_r  <= shift_r;
      valid_r <= 1'b1;
      if (acc_s) begin
        shift_r <= {acc_bit_s, {(WORD_W - 1){1'b0}}};
        cnt_r   <= CNT_W'(1);
      end else begin
        shift_r <= '0;
        cnt_r   <= '0;
      end
    end else begin
      if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
      if (acc_s && !full_s) begin
        shift_r <= {acc_bit_s, shift_r[WORD_W-1:1]};
        cnt_r   <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign osc_en = osc_en_r;
  assign fault  = fault_r;
  assign data   = data_r;
  assign valid  = valid_r;

endmodule

// File: tb/tb_ro_entropy_sampler.sv
// Self-checking bench for ro_entropy_sampler: randomized oscillator inputs,
// a queue-based reference model and a scoreboard monitor on the stream.
module tb_ro_entropy_sampler;

  localparam int WORD_W     = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int WARMUP_CYC = 8;
  localparam int REP_LIMIT  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ready = 1'b0;
  logic f0 = 1'b0, f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  logic osc_en, valid, fault;
  logic [WORD_W-1:0] data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ro_entropy_sampler #(
    .WORD_W(WORD_W), .SAMPLE_DIV(SAMPLE_DIV),
    .WARMUP_CYC(WARMUP_CYC), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .osc_en(osc_en),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .data(data), .valid(valid), .ready(ready), .fault(fault)
  );

`ifdef RO_SAMPLER_VN_EN
  localparam int PLEN = 20;
  bit pat [PLEN] = '{0,1, 1,0, 1,1, 0,0, 1,0, 1,0, 1,0, 1,0, 1,0, 1,0};
  logic [WORD_W-1:0] dir_word = 8'hFE;
`else
  localparam int PLEN = 8;
  bit pat [PLEN] = '{1,0,1,1,0,0,1,0};
  logic [WORD_W-1:0] dir_word = 8'h4D;
`endif

  // reference model: 0 idle, 1 warmup, 2 run, 3 fault
  int  m_st = 0, m_wcnt = 0, m_rcnt = 0, m_rep = 0, m_ticks = 0;
  bit  m_prev = 0, m_phase = 0, m_first = 0, m_valid = 0;
  bit  m_bits [$];
  bit  hist [3] = '{0, 0, 0};
  logic [WORD_W-1:0] exp_q [$];
  bit  cur_osc = 0, cur_fault = 0, cur_valid = 0;
  bit  nx_osc = 0, nx_fault = 0, nx_valid = 0;
  bit  dir_pend = 0;
  bit  held_prev = 0;
  logic [WORD_W-1:0] held_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    if (m_valid && !ready && exp_q.size() > 0) void'(exp_q.pop_back());
    m_valid = 0; m_bits.delete(); m_phase = 0; m_first = 0;
    m_rep = 0; m_prev = 0; m_ticks = 0; m_wcnt = 0; m_rcnt = 0;
  endtask

  task automatic m_reset();
    m_valid = 0; m_bits.delete(); m_phase = 0; m_first = 0;
    m_rep = 0; m_prev = 0; m_ticks = 0; m_wcnt = 0; m_rcnt = 0; m_st = 0;
    exp_q.delete();
    hist = '{0, 0, 0};
    cur_osc = 0; cur_fault = 0; cur_valid = 0;
    nx_osc = 0; nx_fault = 0; nx_valid = 0;
    held_prev = 0;
  endtask

  // predicts the effect of the coming clock edge from this cycle's inputs
  task automatic model_edge();
    bit raw, tick, clr, acc, abit, hs;
    logic [WORD_W-1:0] w;
    if (!rst_n) begin
      m_reset();
      return;
    end
    cur_osc = nx_osc; cur_fault = nx_fault; cur_valid = nx_valid;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = f0 ^ f1 ^ f2 ^ f3;
    raw = hist[2];
    hs = m_valid && ready;
    clr = 0; acc = 0; abit = raw;
    if (!en) begin
      clr = 1; m_st = 0;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_wcnt = 0; end
        1: begin
          m_wcnt++;
          if (m_wcnt == WARMUP_CYC) begin m_st = 2; m_rcnt = 0; end
        end
        2: begin
          m_rcnt++;
          tick = (m_rcnt % SAMPLE_DIV) == 0;
          if (tick) begin
            m_ticks++;
            if (m_rep == 0 || raw != m_prev) m_rep = 1; else m_rep++;
            m_prev = raw;
            if (m_rep == REP_LIMIT) begin
              m_st = 3; clr = 1;
            end else begin
`ifdef RO_SAMPLER_VN_EN
              if (!m_phase) begin
                m_first = raw; m_phase = 1;
              end else begin
                m_phase = 0; acc = (m_first != raw); abit = m_first;
              end
`else
              acc = 1;
`endif
            end
          end
          if (!clr) begin
            if (m_bits.size() == WORD_W && (!m_valid || ready)) begin
              for (int k = 0; k < WORD_W; k++) w[k] = m_bits[k];
              exp_q.push_back(w);
              m_bits.delete();
              m_valid = 1;
            end else if (hs) begin
              m_valid = 0;
            end
            if (acc && m_bits.size() < WORD_W) m_bits.push_back(abit);
          end
        end
        default: ;
      endcase
    end
    if (clr) m_clear();
    nx_osc = (m_st == 1) || (m_st == 2);
    nx_fault = (m_st == 3);
    nx_valid = m_valid;
  endtask

  // one clock of stimulus, driven just after the rising edge
  task automatic cyc(input bit e, input bit r, input bit [3:0] fv);
    @(posedge clk);
    #1;
    en = e; ready = r;
    {f3, f2, f1, f0} = fv;
    model_edge();
  endtask

  function automatic bit [3:0] rnd_f();
    return 4'($urandom_range(0, 15));
  endfunction

  // scoreboard monitor sampling mid-cycle
  always @(negedge clk) begin
    chk("osc_en", {31'd0, osc_en}, {31'd0, cur_osc});
    chk("fault", {31'd0, fault}, {31'd0, cur_fault});
    chk("valid", {31'd0, valid}, {31'd0, cur_valid});
    if (held_prev && cur_valid) chk("data_hold", {24'd0, data}, {24'd0, held_data});
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
      end else begin
        chk("word", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
      if (dir_pend) begin
        chk("directed_word", {24'd0, data}, {24'd0, dir_word});
        dir_pend = 0;
      end
    end
    held_prev = valid && !ready;
    held_data = data;
  end

  initial begin
    int budget;
    // reset state
    repeat (3) cyc(1'b0, 1'b0, 4'd0);
    @(posedge clk); #1; rst_n = 1'b1; model_edge();
    repeat (2) cyc(1'b0, 1'b1, 4'd0);

    // directed pattern through f0 only
    dir_pend = 1;
    for (int i = 0; i < WARMUP_CYC + 2 + PLEN * SAMPLE_DIV + 20; i++)
      cyc(1'b1, 1'b1, {3'd0, (m_ticks < PLEN) ? pat[m_ticks] : 1'b0});
    chk("directed_seen", {31'd0, dir_pend}, 32'd0);

    // randomized run with random ready and occasional en drops
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, rnd_f());

    // consumer stalls across several words, then drains
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, rnd_f());
    for (int i = 0; i < 150; i++) cyc(1'b1, 1'b1, rnd_f());

    // stuck source trips the repetition test
    cyc(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < WARMUP_CYC + 2 + REP_LIMIT * SAMPLE_DIV + 12; i++)
      cyc(1'b1, 1'b1, 4'd0);
    chk("stuck_fault", {31'd0, fault}, 32'd1);
    chk("stuck_osc_off", {31'd0, osc_en}, 32'd0);
    chk("stuck_valid", {31'd0, valid}, 32'd0);
    cyc(1'b0, 1'b1, 4'd0);
    cyc(1'b1, 1'b1, rnd_f());
    chk("fault_cleared", {31'd0, fault}, 32'd0);

    // asynchronous reset while a word is held
    budget = 0;
    do begin
      cyc(1'b1, 1'b0, rnd_f());
      budget++;
    end while (!valid && budget < 400);
    chk("valid_before_reset", {31'd0, valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_osc_en", {31'd0, osc_en}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    m_reset();
    repeat (2) cyc(1'b1, 1'b1, rnd_f());
    @(posedge clk); #1; rst_n = 1'b1; en = 1'b1; ready = 1'b1; model_edge();
    for (int i = 0; i < 300; i++) cyc(1'b1, $urandom_range(0, 3) != 0, rnd_f());

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
